// File: rtl/spi_master.sv
// SPI-style framed master: SEL, 10-bit {cmd,din} shift, optional turnaround + 8-bit receive, END.
// Define SPI_MASTER_SEQ_CHECK_EN to reject read-data frames not preceded by a read-address frame.
module spi_master #(
  parameter int TA_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] cmd,
  input  logic [7:0] din,
  input  logic       MISO,
  output logic       MOSI,
  output logic       SS_n,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, SEL, SHIFT, TURN, RECV, END} state_t;

  localparam logic [3:0] TA_LAST = 4'(TA_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [9:0]  frame_q, frame_d;
  logic [7:0]  rx_sh_q, rx_data_q;
  logic        mosi_q, mosi_d;
  logic        ss_n_q, ss_n_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        rx_valid_q, rx_valid_d;
  logic        can_start, reject, accept;
  logic [3:0]  shift_idx;

  assign can_start = (state_q == IDLE) || (state_q == END);
  assign accept    = can_start && start && !reject;

`ifdef SPI_MASTER_SEQ_CHECK_EN
  logic seq_ok_q;
  logic err_q, err_d;

  assign reject = (cmd == 2'b11) && !seq_ok_q;
  assign err_d  = can_start && start && reject;
  assign err    = err_q;

  // Flag follows the command of each frame as it completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_ok_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= err_d;
      if (state_d == END && state_q != END) begin
        if (frame_q[9:8] == 2'b10)
          seq_ok_q <= 1'b1;
        else if (frame_q[9:8] == 2'b11)
          seq_ok_q <= 1'b0;
      end
    end
  end
`else
  assign reject = 1'b0;
  assign err    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      frame_q    <= 10'd0;
      rx_sh_q    <= 8'd0;
      rx_data_q  <= 8'd0;
      mosi_q     <= 1'b0;
      ss_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      frame_q    <= frame_d;
      mosi_q     <= mosi_d;
      ss_n_q     <= ss_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rx_valid_q <= rx_valid_d;
      if (state_q == RECV) begin
        rx_sh_q <= {rx_sh_q[6:0], MISO};
        if (state_d == END)
          rx_data_q <= {rx_sh_q[6:0], MISO};
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SEL;
      SEL:     if (cnt_q == 4'd1) state_d = SHIFT;
      SHIFT:   if (cnt_q == 4'd9) state_d = (frame_q[9:8] == 2'b11) ? TURN : END;
      TURN:    if (cnt_q == TA_LAST) state_d = RECV;
      RECV:    if (cnt_q == 4'd7) state_d = END;
      END:     state_d = accept ? SEL : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Phase counter restarts on every state change and rests at zero while idle.
  assign cnt_d   = (state_d != state_q || state_d == IDLE) ? 4'd0 : cnt_q + 4'd1;
  assign frame_d = accept ? {cmd, din} : frame_q;

  // Outputs are decoded from the next state so they register together with it.
  always_comb begin
    shift_idx  = 4'd9 - cnt_d;
    mosi_d     = 1'b0;
    ss_n_d     = 1'b1;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    rx_valid_d = 1'b0;
    unique case (state_d)
      SEL: begin
        ss_n_d = 1'b0;
        busy_d = 1'b1;
        mosi_d = frame_d[9];
      end
      SHIFT: begin
        ss_n_d = 1'b0;
        busy_d = 1'b1;
        mosi_d = frame_d[shift_idx];
      end
      TURN, RECV: begin
        ss_n_d = 1'b0;
        busy_d = 1'b1;
      end
      END: begin
        done_d     = 1'b1;
        rx_valid_d = (frame_d[9:8] == 2'b11);
      end
      default: ;
    endcase
  end

  assign MOSI     = mosi_q;
  assign SS_n     = ss_n_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule
